// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbitrated single-port data RAM shared by NUM_CORES cores, with a priority tb port.
// Define DMEM_ARB_STATS_EN to add per-core saturating stall counters on port stall_cnt.
module dmem_rr_arbiter #(
   parameter int unsigned NUM_CORES = 4,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned DEPTH     = 1024
) (
   input  logic                          clk,
   input  logic                          RESET,
   input  logic [NUM_CORES-1:0]          req,
   input  logic [NUM_CORES-1:0]          we,
   input  logic [NUM_CORES*ADDR_W-1:0]   addr,
   input  logic [NUM_CORES*DATA_W-1:0]   wdata,
   output logic [NUM_CORES-1:0]          gnt,
   output logic [NUM_CORES-1:0]          rvalid,
   output logic [DATA_W-1:0]             rdata,
   input  logic                          tb_en,
   input  logic                          tb_we,
   input  logic [ADDR_W-1:0]             tb_addr,
   input  logic [DATA_W-1:0]             tb_wdata,
   output logic [DATA_W-1:0]             tb_rdata,
   output logic                          busy
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [NUM_CORES*16-1:0]       stall_cnt
`endif
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PW = $clog2(NUM_CORES);

   logic [PW-1:0]     rr_ptr;
   logic [PW-1:0]     sel;
   logic [PW-1:0]     cand;
   logic              sel_valid;
   logic [AW-1:0]     core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic              core_we;
   logic [AW-1:0]     tb_idx;
   logic [DATA_W-1:0] mem [DEPTH];

   assign busy   = (|req) | tb_en;
   assign tb_idx = tb_addr[AW-1:0];

   // Search starts at rr_ptr and wraps; the first requester found wins.
   always_comb begin
      gnt       = '0;
      sel       = '0;
      cand      = '0;
      sel_valid = 1'b0;
      if (RESET && !tb_en) begin
         for (int unsigned off = 0; off < NUM_CORES; off++) begin
            cand = PW'((32'(rr_ptr) + off) % NUM_CORES);
            if (!sel_valid && req[cand]) begin
               sel_valid = 1'b1;
               sel       = cand;
            end
         end
         if (sel_valid) gnt[sel] = 1'b1;
      end
   end

   always_comb begin
      core_addr  = '0;
      core_wdata = '0;
      core_we    = 1'b0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         if (sel == PW'(i)) begin
            core_addr  = addr[i*ADDR_W +: AW];
            core_wdata = wdata[i*DATA_W +: DATA_W];
            core_we    = we[i];
         end
      end
   end

   // RAM array carries no reset; accesses are suppressed while reset is held.
   always_ff @(posedge clk) begin
      if (RESET) begin
         if (tb_en) begin
            if (tb_we) mem[tb_idx] <= tb_wdata;
         end else if (sel_valid && core_we) begin
            mem[core_addr] <= core_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         rr_ptr   <= '0;
         rvalid   <= '0;
         rdata    <= '0;
         tb_rdata <= '0;
      end else begin
         rvalid <= '0;
         if (tb_en) begin
            if (!tb_we) tb_rdata <= mem[tb_idx];
         end else if (sel_valid) begin
            rr_ptr <= (sel == PW'(NUM_CORES - 1)) ? '0 : sel + PW'(1);
            if (!core_we) begin
               rvalid[sel] <= 1'b1;
               rdata       <= mem[core_addr];
            end
         end
      end
   end

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         stall_cnt <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (req[i] && !gnt[i] && (stall_cnt[i*16 +: 16] != 16'hFFFF))
               stall_cnt[i*16 +: 16] <= stall_cnt[i*16 +: 16] + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Self-checking bench for dmem_rr_arbiter: directed vector table, hand sequences, randomized model run.
module tb_dmem_rr_arbiter;

   localparam int unsigned N   = 4;
   localparam int unsigned DW  = 16;
   localparam int unsigned AWD = 16;

   logic              clk = 1'b0;
   logic              RESET;
   logic [N-1:0]      req, we, gnt, rvalid;
   logic [N*AWD-1:0]  addr;
   logic [N*DW-1:0]   wdata;
   logic [DW-1:0]     rdata, tb_rdata, tb_addr, tb_wdata;
   logic              tb_en, tb_we, busy;
`ifdef DMEM_ARB_STATS_EN
   logic [N*16-1:0]   stall_cnt;
`endif

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   dmem_rr_arbiter #(.NUM_CORES(N), .DATA_W(DW), .ADDR_W(AWD), .DEPTH(1024)) dut (
`ifdef DMEM_ARB_STATS_EN
      .stall_cnt(stall_cnt),
`endif
      .clk(clk), .RESET(RESET), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .tb_en(tb_en), .tb_we(tb_we),
      .tb_addr(tb_addr), .tb_wdata(tb_wdata), .tb_rdata(tb_rdata), .busy(busy)
   );

   typedef struct {
      logic [3:0]  rq, wr;
      logic [15:0] a, d;
      logic        te, tw;
      logic [15:0] ta, td;
      logic [3:0]  g, rv;
      logic        crd;
      logic [15:0] rd;
      logic        ctb;
      logic [15:0] trd;
   } vec_t;

   vec_t tbl [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic idle();
      req = '0; we = '0; addr = '0; wdata = '0;
      tb_en = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_wdata = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_core(input int i, input logic r, input logic w,
                           input logic [15:0] a, input logic [15:0] d);
      req[i] = r; we[i] = w;
      addr[i*AWD +: AWD] = a;
      wdata[i*DW +: DW]  = d;
   endtask

   task automatic do_reset();
      @(negedge clk);
      RESET = 1'b0;
      idle();
      step();
      step();
      #2 RESET = 1'b1;
      step();
   endtask

   // Reference model state: priority list (head = highest priority) and memory image.
   int          prio[$];
   logic [15:0] mmem [int];
   logic [3:0]  m_rv;
   logic [15:0] m_rdata, m_tb;
   logic [N-1:0] hold;

   initial begin
      idle();
      RESET = 1'b0;

      // Reset state with requests present
      req = 4'b1111;
      step();
      @(negedge clk);
      check("reset_gnt", 32'(gnt), 32'h0);
      check("reset_rvalid", 32'(rvalid), 32'h0);
      check("reset_rdata", 32'(rdata), 32'h0);
      check("reset_tb_rdata", 32'(tb_rdata), 32'h0);
      check("reset_busy", 32'(busy), 32'h1);
      idle();
      #2 RESET = 1'b1;
      step();

      // Directed vectors: gnt is this row's grant; rvalid/rdata/tb_rdata reflect the previous row
      tbl[0]  = '{4'b0100, 4'b0100, 16'h0010, 16'h00AB, 1'b0, 1'b0, 16'h0, 16'h0, 4'b0100, 4'b0000, 1'b0, 16'h0,    1'b0, 16'h0};
      tbl[1]  = '{4'b0100, 4'b0000, 16'hFC10, 16'h0,    1'b0, 1'b0, 16'h0, 16'h0, 4'b0100, 4'b0000, 1'b0, 16'h0,    1'b0, 16'h0};
      tbl[2]  = '{4'b0000, 4'b0000, 16'h0,    16'h0,    1'b0, 1'b0, 16'h0, 16'h0, 4'b0000, 4'b0100, 1'b1, 16'h00AB, 1'b0, 16'h0};
      tbl[3]  = '{4'b0001, 4'b0001, 16'h0020, 16'h0C00, 1'b0, 1'b0, 16'h0, 16'h0, 4'b0001, 4'b0000, 1'b1, 16'h00AB, 1'b0, 16'h0};
      tbl[4]  = '{4'b1001, 4'b0000, 16'h0020, 16'h0,    1'b0, 1'b0, 16'h0, 16'h0, 4'b1000, 4'b0000, 1'b0, 16'h0,    1'b0, 16'h0};
      tbl[5]  = '{4'b0001, 4'b0000, 16'h0020, 16'h0,    1'b0, 1'b0, 16'h0, 16'h0, 4'b0001, 4'b1000, 1'b1, 16'h0C00, 1'b0, 16'h0};
      tbl[6]  = '{4'b0000, 4'b0000, 16'h0,    16'h0,    1'b0, 1'b0, 16'h0, 16'h0, 4'b0000, 4'b0001, 1'b1, 16'h0C00, 1'b0, 16'h0};
      tbl[7]  = '{4'b0010, 4'b0000, 16'h0005, 16'h0,    1'b1, 1'b1, 16'h5, 16'h1234, 4'b0000, 4'b0000, 1'b0, 16'h0, 1'b0, 16'h0};
      tbl[8]  = tbl[7];
      tbl[9]  = tbl[7];
      tbl[10] = '{4'b0010, 4'b0000, 16'h0005, 16'h0,    1'b0, 1'b0, 16'h0, 16'h0, 4'b0010, 4'b0000, 1'b0, 16'h0,    1'b0, 16'h0};
      tbl[11] = '{4'b0000, 4'b0000, 16'h0,    16'h0,    1'b1, 1'b0, 16'h5, 16'h0, 4'b0000, 4'b0010, 1'b1, 16'h1234, 1'b0, 16'h0};
      tbl[12] = '{4'b0000, 4'b0000, 16'h0,    16'h0,    1'b0, 1'b0, 16'h0, 16'h0, 4'b0000, 4'b0000, 1'b0, 16'h0,    1'b1, 16'h1234};

      for (int r = 0; r < 13; r++) begin
         for (int i = 0; i < int'(N); i++) set_core(i, tbl[r].rq[i], tbl[r].wr[i], tbl[r].a, tbl[r].d);
         tb_en = tbl[r].te; tb_we = tbl[r].tw; tb_addr = tbl[r].ta; tb_wdata = tbl[r].td;
         @(negedge clk);
         check($sformatf("vec%0d_gnt", r), 32'(gnt), 32'(tbl[r].g));
         check($sformatf("vec%0d_rvalid", r), 32'(rvalid), 32'(tbl[r].rv));
         check($sformatf("vec%0d_busy", r), 32'(busy), 32'((|tbl[r].rq) | tbl[r].te));
         if (tbl[r].crd) check($sformatf("vec%0d_rdata", r), 32'(rdata), 32'(tbl[r].rd));
         if (tbl[r].ctb) check($sformatf("vec%0d_tb_rdata", r), 32'(tb_rdata), 32'(tbl[r].trd));
         step();
      end
      idle();

      // Preload per-core data, then all cores read continuously from reset
      for (int i = 0; i < int'(N); i++) begin
         tb_en = 1'b1; tb_we = 1'b1; tb_addr = 16'h0040 + 16'(i); tb_wdata = 16'hA000 + 16'(i);
         step();
      end
      idle();
      do_reset();
      for (int i = 0; i < int'(N); i++) set_core(i, 1'b1, 1'b0, 16'h0040 + 16'(i), 16'h0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check($sformatf("all_gnt%0d", c), 32'(gnt), 32'(1) << (c % 4));
         if (c == 0) check("all_rvalid0", 32'(rvalid), 32'h0);
         else begin
            check($sformatf("all_rvalid%0d", c), 32'(rvalid), 32'(1) << ((c - 1) % 4));
            check($sformatf("all_rdata%0d", c), 32'(rdata), 32'hA000 + 32'((c - 1) % 4));
         end
         step();
      end
      idle();
      @(negedge clk);
      check("all_rvalid_tail", 32'(rvalid), 32'b0010);
      step();

      // Async reset between core 0 read grant and its commit edge
      set_core(0, 1'b1, 1'b1, 16'h0030, 16'hBEEF);
      step();
      set_core(0, 1'b1, 1'b0, 16'h0030, 16'h0);
      @(negedge clk);
      check("rst_mid_gnt", 32'(gnt), 32'b0001);
      #1 RESET = 1'b0;
      #1 check("rst_mid_gnt_held", 32'(gnt), 32'h0);
      step();
      check("rst_mid_rvalid", 32'(rvalid), 32'h0);
      idle();
      #2 RESET = 1'b1;
      step();
      req = 4'b1111;
      @(negedge clk);
      check("rst_ptr_zero", 32'(gnt), 32'b0001);
      step();
      idle();
      tb_en = 1'b1; tb_addr = 16'h0030;
      step();
      tb_addr = 16'h0005;
      @(negedge clk);
      check("rst_ram_kept_30", 32'(tb_rdata), 32'hBEEF);
      step();
      idle();
      @(negedge clk);
      check("rst_ram_kept_05", 32'(tb_rdata), 32'h1234);
      step();

      // Randomized run against the priority-list model
      do_reset();
      prio = {};
      for (int i = 0; i < int'(N); i++) prio.push_back(i);
      m_rv = '0; m_rdata = '0; m_tb = '0; hold = '0;
      for (int c = 0; c < 2000; c++) begin
         int k;
         logic [3:0] eg;
         for (int i = 0; i < int'(N); i++) begin
            if (!(hold[i] && $urandom_range(0, 19) != 0)) begin
               set_core(i, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                        {6'($urandom_range(0, 63)), 10'h100 + 10'($urandom_range(0, 15))},
                        16'($urandom));
               hold[i] = req[i];
            end
         end
         tb_en    = (c < 16) ? 1'b1 : ($urandom_range(0, 7) == 0);
         tb_we    = (c < 16) ? 1'b1 : 1'($urandom_range(0, 1));
         tb_addr  = (c < 16) ? 16'h0100 + 16'(c)
                             : {6'($urandom_range(0, 63)), 10'h100 + 10'($urandom_range(0, 15))};
         tb_wdata = 16'($urandom);

         k = -1;
         if (!tb_en) foreach (prio[j]) if (k < 0 && req[prio[j]]) k = prio[j];
         eg = (k >= 0) ? 4'(1 << k) : 4'b0;
         @(negedge clk);
         check("rnd_gnt", 32'(gnt), 32'(eg));
         check("rnd_rvalid", 32'(rvalid), 32'(m_rv));
         check("rnd_rdata", 32'(rdata), 32'(m_rdata));
         check("rnd_tb_rdata", 32'(tb_rdata), 32'(m_tb));
         check("rnd_busy", 32'(busy), 32'((|req) | tb_en));

         m_rv = '0;
         if (tb_en) begin
            if (tb_we) mmem[int'(tb_addr[9:0])] = tb_wdata;
            else       m_tb = mmem[int'(tb_addr[9:0])];
         end else if (k >= 0) begin
            if (we[k]) mmem[int'(addr[k*AWD +: 10])] = wdata[k*DW +: DW];
            else begin
               m_rv = 4'(1 << k);
               m_rdata = mmem[int'(addr[k*AWD +: 10])];
            end
            hold[k] = 1'b0;
            while (prio[$] != k) prio.push_back(prio.pop_front());
         end
         step();
      end
      idle();

`ifdef DMEM_ARB_STATS_EN
      do_reset();
      @(negedge clk);
      check("stats_reset", 32'(stall_cnt[15:0]), 32'h0);
      step();
      req = 4'b1111;
      for (int c = 0; c < 8; c++) step();
      idle();
      for (int i = 0; i < int'(N); i++)
         check($sformatf("stats_cnt%0d", i), 32'(stall_cnt[i*16 +: 16]), 32'd6);
      req = 4'b0001; tb_en = 1'b1;
      for (int c = 0; c < 70000; c++) step();
      idle();
      check("stats_sat", 32'(stall_cnt[15:0]), 32'hFFFF);
      check("stats_other", 32'(stall_cnt[31:16]), 32'd6);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/dmem_rr_arbiter.md
Name: dmem_rr_arbiter

Overview:
- Parametrised successor to the fixed 4-port data memory.
- NUM_CORES core request channels share one single-port data RAM, with a round-robin arbiter and a req/gnt/rvalid handshake.
- A testbench load/dump port has absolute priority over all cores.
- Sits between the core array and data storage in top; it replaces the per-core ports of the 4-port memory.

Parameters:
- NUM_CORES, 4, number of core request channels (2..16).
- DATA_W, 16, data word width.
- ADDR_W, 16, address width on every port.
- DEPTH, 1024, RAM words (power of two); the RAM is indexed by addr[log2(DEPTH)-1:0] and upper bits are ignored.

Ports:
- clk  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-low reset.
- req  input  NUM_CORES  per-core access request.
- we  input  NUM_CORES  per-core write enable (1=write, 0=read); valid with req.
- addr  input  NUM_CORES*ADDR_W  flattened per-core address; core i at [i*ADDR_W +: ADDR_W].
- wdata  input  NUM_CORES*DATA_W  flattened per-core write data.
- gnt  output  NUM_CORES  one-hot grant (combinational, same cycle as the request).
- rvalid  output  NUM_CORES  one-hot: read data for core i is valid this cycle.
- rdata  output  DATA_W  shared read-data bus, qualified by rvalid.
- tb_en  input  1  testbench port access request.
- tb_we  input  1  testbench write enable.
- tb_addr  input  ADDR_W  testbench address.
- tb_wdata  input  DATA_W  testbench write data.
- tb_rdata  output  DATA_W  testbench read data, valid one cycle after a tb read.
- busy  output  1  high when any req bit or tb_en is high.

Behaviour:
- Reset (RESET=0, asynchronous):
  - rr_ptr=0; rvalid=0; rdata=0; tb_rdata=0.
  - gnt is 0 while reset is held.
  - RAM contents are not reset.
  - A read in flight when reset asserts is discarded, so no rvalid follows.
- Arbitration, evaluated every cycle:
  - If tb_en=1: gnt=0, the tb access executes, and rr_ptr is unchanged.
  - Otherwise the grantee is the first i with req[i]=1, searching rr_ptr, rr_ptr+1, …, NUM_CORES-1, 0, …, rr_ptr-1 (wrap-around).
  - No request: gnt=0 and rr_ptr holds.
  - After a grant to core k: rr_ptr <= (k+1) mod NUM_CORES, so k has lowest priority next cycle.
- Access commit, at the rising edge of the grant cycle:
  - Write: RAM[addr_k] <= wdata_k.
  - Read: rdata <= RAM[addr_k] and rvalid[k] <= 1 for exactly one cycle (1-cycle latency).
  - rvalid is 0 on any cycle that follows no granted read.
- Handshake:
  - A core holds req, we, addr and wdata stable until it sees gnt=1 in the same cycle.
  - Dropping req before gnt cancels the request without side effects.
  - Back-to-back grants to different cores are allowed every cycle, so rvalid may be high on consecutive cycles for different cores.
  - rdata is held until the next granted read.
- tb port:
  - Write: RAM[tb_addr] <= tb_wdata.
  - Read: tb_rdata <= RAM[tb_addr] on the next edge. tb_rdata holds otherwise.
  - tb_en takes priority; pending core requests stall, with no data loss, and resume with the saved rr_ptr.
- Read-during-write: the RAM is single-port and only one access commits per cycle, so no read/write collision exists.
  - A read granted the cycle after a write to the same address returns the new data.
- No starvation: with every core requesting continuously, each core is granted once per NUM_CORES cycles.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined:
  - Adds output port stall_cnt (NUM_CORES*16 bits, flattened).
  - Per core i, a 16-bit counter increments each cycle req[i]=1 and gnt[i]=0, including tb-stall cycles.
  - The counter saturates at 16'hFFFF and clears on reset.
- When not defined: the port and counters are absent, and all other behaviour is identical.

Test Plan:
1. Single requester: core 2 writes 16'h00AB to 0x0010. Next cycle, core 2 reads 0x0010 → gnt=4'b0100 in both cycles; rvalid=4'b0100 one cycle after the read grant; rdata=16'h00AB.
2. All four cores hold req=1 (reads) from reset → grant order 0,1,2,3,0,1; each core's rvalid appears exactly one cycle after its grant.
3. Fairness after a skip: rr_ptr=1 after granting core 0; core 1 idle; cores 0 and 3 requesting → core 3 granted next, then core 0.
4. tb priority: tb_en=1 with tb write 16'h1234 to 0x0005 for 3 cycles while core 1 requests → gnt=0 for 3 cycles, core 1 granted on cycle 4; a tb read of 0x0005 gives tb_rdata=16'h1234.
5. Async reset mid-read: RESET drops between core 0's read grant and the next edge → rvalid stays 0, rr_ptr=0 after release, and RAM still holds earlier writes (verified by tb read).
6. DMEM_ARB_STATS_EN: all 4 cores request for 8 cycles → stall_cnt = 6,6,6,6. Forcing a stall of 70000 cycles saturates that core's counter at 16'hFFFF.
